// File: rtl/recv_word_buffer_pkg.sv
// Shared constants and types for the receive-side word buffer.
// Bytes arrive least-significant first and are packed into 32-bit words.
package recv_word_buffer_pkg;

   localparam int RECV_FIFO_DEPTH = 256;

   typedef logic [31:0] w32;
   typedef logic [31:0] r32;

   // Completes a word from the three bytes already shifted in plus the final byte.
   function automatic w32 pack_word(input logic [7:0] last_byte, input logic [23:0] shift);
      return {last_byte, shift};
   endfunction

endpackage

// File: rtl/recv_word_buffer_fifo.sv
// Synchronous word FIFO with a separate occupancy counter and registered read data.
// Read-first memory: a simultaneous write and read of the same slot returns the old word.
module word_fifo
   import recv_word_buffer_pkg::*;
#(
   parameter int DEPTH  = RECV_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  w32                wdata,
   input  logic              pop,
   output w32                rdata,
   output logic [ADDR_W:0]   size,
   output logic              full
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   w32                mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   size_q, size_d;
   w32                rdata_q;
   logic              pop_ok_s;
   logic              push_ok_s;

   assign full      = (size_q == FULL_CNT);
   assign pop_ok_s  = pop && (size_q != {(ADDR_W+1){1'b0}});
   assign push_ok_s = push && (!full || pop_ok_s);

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      size_d   = size_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   size_d = size_q + (ADDR_W+1)'(1);
         2'b01:   size_d = size_q - (ADDR_W+1)'(1);
         default: size_d = size_q;
      endcase
   end

   // Pointer, occupancy and read-data registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= {ADDR_W{1'b0}};
         rd_ptr_q <= {ADDR_W{1'b0}};
         size_q   <= {(ADDR_W+1){1'b0}};
         rdata_q  <= 32'h0000_0000;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         size_q   <= size_d;
         if (pop_ok_s) begin
            rdata_q <= mem[rd_ptr_q];
         end
      end
   end

   // Storage array kept free of reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = rdata_q;
   assign size  = size_q;

endmodule

// File: rtl/recv_word_buffer.sv
// Receive buffer: packs UART bytes into little-endian words and queues them for the core.
// Holds the byte packer, framing-error handling and the sticky status flags.
module recv_word_buffer
   import recv_word_buffer_pkg::*;
#(
   parameter int DEPTH  = RECV_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_frame_err,
   input  logic              recv_en,
   output logic [ADDR_W:0]   recv_size,
   output w32                recv_rd,
   output logic              overflow,
   output logic              frame_err
);

   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] shift_q, shift_d;
   logic        overflow_q, overflow_d;
   logic        frame_err_q, frame_err_d;
   logic        byte_ok_s;
   logic        bad_byte_s;
   logic        word_done_s;
   logic        pop_ok_s;
   logic        fifo_full_s;
   w32          word_s;

   assign byte_ok_s   = rx_valid && !rx_frame_err;
   assign bad_byte_s  = rx_valid && rx_frame_err;
   assign word_done_s = byte_ok_s && (byte_cnt_q == 2'd3);
   assign word_s      = pack_word(rx_data, shift_q);
   assign pop_ok_s    = recv_en && (recv_size != {(ADDR_W+1){1'b0}});

   // Byte packer and sticky flags; a completed word that finds no room is lost.
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      overflow_d  = overflow_q;
      frame_err_d = frame_err_q;
      if (bad_byte_s) begin
         byte_cnt_d  = 2'd0;
         frame_err_d = 1'b1;
      end else if (byte_ok_s) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         shift_d    = {rx_data, shift_q[23:8]};
         if (word_done_s && fifo_full_s && !pop_ok_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
      end else begin
         byte_cnt_d = byte_cnt_q;
      end
   end

   // Packer and status registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         byte_cnt_q  <= 2'd0;
         shift_q     <= 24'h00_0000;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   word_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (word_done_s),
      .wdata (word_s),
      .pop   (recv_en),
      .rdata (recv_rd),
      .size  (recv_size),
      .full  (fifo_full_s)
   );

   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_recv_word_buffer.sv
// Bench for recv_word_buffer at DEPTH=4: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the buffer.
module tb_recv_word_buffer;
   import recv_word_buffer_pkg::*;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clock = 1'b0;
   logic              reset;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_frame_err;
   logic              recv_en;
   logic [ADDR_W:0]   recv_size;
   w32                recv_rd;
   logic              overflow;
   logic              frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   w32         m_q[$];
   logic [7:0] m_bytes[$];
   w32         m_rd;
   logic       m_ovf;
   logic       m_ferr;

   recv_word_buffer #(.DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_frame_err (rx_frame_err),
      .recv_en      (recv_en),
      .recv_size    (recv_size),
      .recv_rd      (recv_rd),
      .overflow     (overflow),
      .frame_err    (frame_err)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic rst, input logic v, input logic [7:0] d,
                             input logic fe, input logic en);
      w32 w;
      if (!rst) begin
         m_q.delete();
         m_bytes.delete();
         m_rd   = 32'h0;
         m_ovf  = 1'b0;
         m_ferr = 1'b0;
      end else begin
         if (en && m_q.size() != 0) m_rd = m_q.pop_front();
         if (v && fe) begin
            m_bytes.delete();
            m_ferr = 1'b1;
         end else if (v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
               w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
               m_bytes.delete();
               if (m_q.size() < DEPTH) m_q.push_back(w);
               else m_ovf = 1'b1;
            end
         end
      end
   endtask

   // one clock with the given inputs, then compare every output against the model
   task automatic cycle(input logic rst, input logic v, input logic [7:0] d,
                        input logic fe, input logic en);
      reset        = rst;
      rx_valid     = v;
      rx_data      = d;
      rx_frame_err = fe;
      recv_en      = en;
      @(posedge clock);
      model_step(rst, v, d, fe, en);
      #1;
      check_val("size", 32'(recv_size), 32'(m_q.size()));
      check_val("rd",   recv_rd, m_rd);
      check_val("ovf",  32'(overflow), 32'(m_ovf));
      check_val("ferr", 32'(frame_err), 32'(m_ferr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, 1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic pop1();
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic send_word(input w32 w);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      int en_pct;
      reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_frame_err = 1'b0; recv_en = 1'b0;
      m_rd = 32'h0; m_ovf = 1'b0; m_ferr = 1'b0;
      do_reset();

      // little-endian packing and pop latency
      send_word(32'h1234_5678);
      check_val("size_1", 32'(recv_size), 32'd1);
      send_word(32'hDEAD_BEEF);
      check_val("size_2", 32'(recv_size), 32'd2);
      pop1();
      check_val("rd_first", recv_rd, 32'h1234_5678);
      pop1();
      check_val("rd_second", recv_rd, 32'hDEAD_BEEF);
      check_val("size_0", 32'(recv_size), 32'd0);

      // framing error drops the partial word
      send(8'h11); send(8'h22);
      cycle(1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
      send_word(32'h0403_0201);
      check_val("ferr_set", 32'(frame_err), 32'd1);
      check_val("ferr_one_word", 32'(recv_size), 32'd1);
      pop1();
      check_val("ferr_rd", recv_rd, 32'h0403_0201);

      // overflow on a full FIFO
      do_reset();
      for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i));
      check_val("ovf_set", 32'(overflow), 32'd1);
      check_val("ovf_size", 32'(recv_size), 32'd4);
      for (int i = 0; i < 4; i++) begin
         pop1();
         check_val("ovf_order", recv_rd, 32'hA000_0000 + 32'(i));
      end

      // full FIFO with a word completing in the same cycle as a pop
      do_reset();
      for (int i = 0; i < 4; i++) send_word(32'hB000_0000 + 32'(i));
      send(8'h44); send(8'h33); send(8'h22);
      cycle(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
      check_val("fullpop_rd", recv_rd, 32'hB000_0000);
      check_val("fullpop_size", 32'(recv_size), 32'd4);
      check_val("fullpop_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) pop1();
      check_val("fullpop_new", recv_rd, 32'h1122_3344);

      // pop on empty is ignored
      for (int i = 0; i < 5; i++) pop1();
      check_val("empty_rd", recv_rd, 32'h1122_3344);
      send_word(32'hCAFE_F00D);
      pop1();
      check_val("empty_next", recv_rd, 32'hCAFE_F00D);

      // reset mid-word with words queued
      for (int i = 0; i < 3; i++) send_word(32'hC000_0000 + 32'(i));
      pop1();
      send(8'h55); send(8'h66);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check_val("rst_size", 32'(recv_size), 32'd0);
      check_val("rst_rd", recv_rd, 32'h0);
      check_val("rst_ferr", 32'(frame_err), 32'd0);
      send_word(32'h8765_4321);
      pop1();
      check_val("rst_fresh", recv_rd, 32'h8765_4321);

      // random traffic at several pop rates
      for (int seg = 0; seg < 4; seg++) begin
         en_pct = 10 + 27 * seg;
         for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 99) < 60),
                  8'($urandom),
                  ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < en_pct));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
